ex_stage_mdu: RTL and testbench

//  Execute stage directly downstream of the ID/EX pipeline register. Computes ALU results
//  (RV32I R/I arithmetic) and RV32M multiply/divide on an iterative shift-add/subtract unit.

---
 rtl/ex_stage_mdu.sv | 204 ++++++++++++++++++++
 tb/tb_ex_stage_mdu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_mdu.sv
// Execute stage: RV32I ALU plus an iterative RV32M unit feeding an integrated EX/MEM register.
// Define MDU_DIV_EN to build the iterative divider; without it DIV/DIVU/REM/REMU are flagged illegal_op.
module ex_stage_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] IMM,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic [4:0]      rd,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic            ALUsrc,
    input  logic            wreg,
    input  logic            WMM,
    input  logic            RMM,
    input  logic            MOA,
    input  logic            jal_jalr,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] rd2_out,
    output logic [4:0]      rd_out,
    output logic            wreg_out,
    output logic            WMM_out,
    output logic            RMM_out,
    output logic            MOA_out,
    output logic            stall,
    output logic            illegal_op
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   opb_q;
    logic [1:0]        f3_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN:0]     mul_sum;

    logic [XLEN-1:0] op_b, alu_res, m_res, ex_res;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            mdu_op, mdu_iter, illegal_now;
    logic            signed_a, signed_b, neg_a, neg_b, special;

`ifdef MDU_DIV_EN
    logic            div_q, special_q;
    logic [XLEN:0]   div_sh, div_diff;
`endif

    // ---------------- ALU ----------------
    assign op_b = ALUsrc ? IMM : rd2;

    always_comb begin
        alu_res = '0;
        case (func3)
            3'b000: alu_res = (func7[5] && !ALUsrc) ? rd1 - op_b : rd1 + op_b;
            3'b001: alu_res = rd1 << op_b[SW-1:0];
            3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(rd1) < $signed(op_b)};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, rd1 < op_b};
            3'b100: alu_res = rd1 ^ op_b;
            3'b101: begin
                // kept out of a ?: so the arithmetic shift stays in signed context
                if (func7[5]) alu_res = $signed(rd1) >>> op_b[SW-1:0];
                else          alu_res = rd1 >> op_b[SW-1:0];
            end
            3'b110: alu_res = rd1 | op_b;
            default: alu_res = rd1 & op_b;
        endcase
    end

    // ---------------- M-op decode ----------------
    assign mdu_op = !ALUsrc && (func7 == 7'b0000001) && !jal_jalr;

`ifdef MDU_DIV_EN
    assign mdu_iter    = mdu_op;
    assign illegal_now = 1'b0;
    assign signed_a    = func3[2] ? !func3[0] : (func3[1:0] != 2'b11);
    assign signed_b    = func3[2] ? !func3[0] : !func3[1];
    assign special     = func3[2] && ((rd2 == '0) ||
                         (!func3[0] && rd1 == {1'b1, {(XLEN-1){1'b0}}} && rd2 == '1));
`else
    assign mdu_iter    = mdu_op && !func3[2];
    assign illegal_now = mdu_op && func3[2];
    assign signed_a    = (func3[1:0] != 2'b11);
    assign signed_b    = !func3[1];
    assign special     = 1'b0;
`endif

    assign neg_a = signed_a && rd1[XLEN-1];
    assign neg_b = signed_b && rd2[XLEN-1];
    assign abs_a = neg_a ? -rd1 : rd1;
    assign abs_b = neg_b ? -rd2 : rd2;

    // One iteration: multiply adds into the high half then shifts right;
    // divide shifts the remainder/quotient pair left and restores on borrow.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
        acc_next = {mul_sum, acc[XLEN-1:1]};
`ifdef MDU_DIV_EN
        div_sh   = acc[2*XLEN-1:XLEN-1];
        div_diff = div_sh - {1'b0, opb_q};
        if (div_q) begin
            if (!div_diff[XLEN]) acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else                 acc_next = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
`endif
    end

    assign prod = (neg_a_q ^ neg_b_q) ? -acc : acc;

    always_comb begin
        m_res = (f3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
        if (div_q) begin
            if (special_q) begin
                if (rd2 == '0) m_res = f3_q[1] ? rd1 : '1;
                else           m_res = f3_q[1] ? '0 : rd1;
            end else if (f3_q[1]) begin
                m_res = neg_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
            end else begin
                m_res = (neg_a_q ^ neg_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            end
        end
`endif
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = mdu_iter && (state != DONE) && !flush;
        case (state)
            IDLE:    if (mdu_iter) state_next = special ? DONE : BUSY;
            BUSY:    if (cnt == CW'(XLEN-1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            opb_q   <= '0;
            f3_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
`ifdef MDU_DIV_EN
            div_q     <= 1'b0;
            special_q <= 1'b0;
`endif
        end else if (state == IDLE && mdu_iter && !flush) begin
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, abs_a};
            opb_q   <= abs_b;
            f3_q    <= func3[1:0];
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
`ifdef MDU_DIV_EN
            div_q     <= func3[2];
            special_q <= special;
`endif
        end else if (state == BUSY) begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
        end
    end

    // ---------------- EX/MEM register ----------------
    assign ex_res = jal_jalr ? IMM : (mdu_op ? (illegal_now ? '0 : m_res) : alu_res);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_result_out <= '0;
            rd2_out        <= '0;
            rd_out         <= '0;
            wreg_out       <= 1'b0;
            WMM_out        <= 1'b0;
            RMM_out        <= 1'b0;
            MOA_out        <= 1'b0;
            illegal_op     <= 1'b0;
        end else if (!stall) begin
            alu_result_out <= ex_res;
            rd2_out        <= rd2;
            rd_out         <= rd;
            wreg_out       <= wreg && !illegal_now;
            WMM_out        <= WMM;
            RMM_out        <= RMM;
            MOA_out        <= MOA;
            illegal_op     <= illegal_now;
        end
    end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Scoreboard bench for ex_stage_mdu: directed ALU/M-op vectors, flush abort and reset checks.
module tb_ex_stage_mdu;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [31:0] IMM, rd1, rd2;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        ALUsrc, wreg, WMM, RMM, MOA, jal_jalr;
    logic [31:0] alu_result_out, rd2_out;
    logic [4:0]  rd_out;
    logic        wreg_out, WMM_out, RMM_out, MOA_out, stall, illegal_op;

    ex_stage_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .IMM(IMM), .rd1(rd1), .rd2(rd2),
        .rd(rd), .func3(func3), .func7(func7), .ALUsrc(ALUsrc), .wreg(wreg),
        .WMM(WMM), .RMM(RMM), .MOA(MOA), .jal_jalr(jal_jalr),
        .alu_result_out(alu_result_out), .rd2_out(rd2_out), .rd_out(rd_out),
        .wreg_out(wreg_out), .WMM_out(WMM_out), .RMM_out(RMM_out), .MOA_out(MOA_out),
        .stall(stall), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a, b, imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        src, jal;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ill;
        int          nstall;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res, st;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    logic tb_valid = 1'b0;
    logic cap_prev = 1'b0;
    exp_t m_e;

    function automatic vec_t mk(string nm, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                logic [2:0] f3, logic [6:0] f7, logic src, logic jal,
                                logic [31:0] res, logic ill, int nstall);
        vec_t v;
        v.name = nm; v.a = a; v.b = b; v.imm = imm; v.f3 = f3; v.f7 = f7;
        v.src = src; v.jal = jal; v.res = res; v.ill = ill; v.nstall = nstall;
        v.ctl = 4'b1000; v.rd = 5'd1;
        return v;
    endfunction

    // Monitor: an EX/MEM capture happened at the posedge between two negedges
    always @(negedge clk) begin
        if (cap_prev) begin
            if (sb.size() == 0) begin
                errors++; checks++;
                $display("FAIL unexpected_capture result=%h", alu_result_out);
            end else begin
                m_e = sb.pop_front();
                checks++;
                if (alu_result_out !== m_e.res) begin
                    errors++;
                    $display("FAIL %s result got=%h exp=%h", m_e.name, alu_result_out, m_e.res);
                end
                checks++;
                if ({wreg_out, WMM_out, RMM_out, MOA_out, illegal_op} !== {m_e.ctl, m_e.ill}) begin
                    errors++;
                    $display("FAIL %s ctl/illegal got=%b%b exp=%b%b", m_e.name,
                             {wreg_out, WMM_out, RMM_out, MOA_out}, illegal_op, m_e.ctl, m_e.ill);
                end
                checks++;
                if (rd_out !== m_e.rd || rd2_out !== m_e.st) begin
                    errors++;
                    $display("FAIL %s rd/rd2 got=%0d/%h exp=%0d/%h", m_e.name,
                             rd_out, rd2_out, m_e.rd, m_e.st);
                end
            end
        end
        cap_prev = tb_valid && (!stall || flush) && !rst;
    end

    task automatic drive(input vec_t v);
        @(posedge clk); #1;
        rd1 = v.a; rd2 = v.b; IMM = v.imm; func3 = v.f3; func7 = v.f7;
        ALUsrc = v.src; jal_jalr = v.jal; {wreg, WMM, RMM, MOA} = v.ctl; rd = v.rd;
        flush = 1'b0; tb_valid = 1'b1;
    endtask

    task automatic count_stall(output int n);
        n = 0;
        @(negedge clk);
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        int   n;
        drive(v);
        e.name = v.name; e.res = v.res; e.st = v.b; e.rd = v.rd; e.ill = v.ill;
        e.ctl = {v.ctl[3] & ~v.ill, v.ctl[2:0]};
        sb.push_back(e);
        count_stall(n);
        checks++;
        if (n != v.nstall) begin
            errors++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", v.name, n, v.nstall);
        end
    endtask

    initial begin
        vec_t v;
        exp_t b;
        int   n;

        rst = 1'b1; flush = 1'b0;
        rd1 = 32'd5; rd2 = 32'd9; IMM = 32'hFFFFFFF9; rd = 5'd3; func3 = 3'b000;
        func7 = 7'h00; ALUsrc = 1'b1; jal_jalr = 1'b0;
        {wreg, WMM, RMM, MOA} = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (alu_result_out !== 32'd0 || rd2_out !== 32'd0 || rd_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h/%0d exp=0/0/0", alu_result_out, rd2_out, rd_out);
        end
        checks++;
        if ({wreg_out, WMM_out, RMM_out, MOA_out, illegal_op} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=00000", {wreg_out, WMM_out, RMM_out, MOA_out, illegal_op});
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got=%b exp=0", stall);
        end
        rst = 1'b0;

        vecs.push_back(mk("add_imm", 32'd5, 32'd0, 32'hFFFFFFF9, 3'b000, 7'h00, 1, 0, 32'hFFFFFFFE, 0, 0));
        vecs.push_back(mk("sub", 32'd10, 32'd3, 32'd0, 3'b000, 7'h20, 0, 0, 32'd7, 0, 0));
        vecs.push_back(mk("sra", 32'h80000000, 32'd4, 32'd0, 3'b101, 7'h20, 0, 0, 32'hF8000000, 0, 0));
        vecs.push_back(mk("srl", 32'h80000000, 32'd4, 32'd0, 3'b101, 7'h00, 0, 0, 32'h08000000, 0, 0));
        vecs.push_back(mk("sll_imm", 32'd1, 32'd0, 32'd31, 3'b001, 7'h00, 1, 0, 32'h80000000, 0, 0));
        vecs.push_back(mk("slt", 32'hFFFFFFFF, 32'd1, 32'd0, 3'b010, 7'h00, 0, 0, 32'd1, 0, 0));
        vecs.push_back(mk("sltu", 32'hFFFFFFFF, 32'd1, 32'd0, 3'b011, 7'h00, 0, 0, 32'd0, 0, 0));
        vecs.push_back(mk("xor", 32'hF0F0, 32'hFF00, 32'd0, 3'b100, 7'h00, 0, 0, 32'h0FF0, 0, 0));
        vecs.push_back(mk("or", 32'hF0F0, 32'hFF00, 32'd0, 3'b110, 7'h00, 0, 0, 32'hFFF0, 0, 0));
        vecs.push_back(mk("and", 32'hF0F0, 32'hFF00, 32'd0, 3'b111, 7'h00, 0, 0, 32'hF000, 0, 0));
        vecs.push_back(mk("jal_link", 32'd1, 32'd2, 32'h1004, 3'b000, 7'h01, 0, 1, 32'h1004, 0, 0));
        vecs.push_back(mk("mulh", 32'hFFFFFFFE, 32'd3, 32'd0, 3'b001, 7'h01, 0, 0, 32'hFFFFFFFF, 0, 33));
        vecs.push_back(mk("mul", 32'hFFFFFFFD, 32'd7, 32'd0, 3'b000, 7'h01, 0, 0, 32'hFFFFFFEB, 0, 33));
        vecs.push_back(mk("mulhu", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 3'b011, 7'h01, 0, 0, 32'hFFFFFFFE, 0, 33));
        vecs.push_back(mk("mulhsu", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 3'b010, 7'h01, 0, 0, 32'hFFFFFFFF, 0, 33));
`ifdef MDU_DIV_EN
        vecs.push_back(mk("div_by0", 32'd7, 32'd0, 32'd0, 3'b100, 7'h01, 0, 0, 32'hFFFFFFFF, 0, 1));
        vecs.push_back(mk("rem_ovf", 32'h80000000, 32'hFFFFFFFF, 32'd0, 3'b110, 7'h01, 0, 0, 32'd0, 0, 1));
        vecs.push_back(mk("div_ovf", 32'h80000000, 32'hFFFFFFFF, 32'd0, 3'b100, 7'h01, 0, 0, 32'h80000000, 0, 1));
        vecs.push_back(mk("remu_by0", 32'd7, 32'd0, 32'd0, 3'b111, 7'h01, 0, 0, 32'd7, 0, 1));
        vecs.push_back(mk("div", 32'hFFFFFFF9, 32'd2, 32'd0, 3'b100, 7'h01, 0, 0, 32'hFFFFFFFD, 0, 33));
        vecs.push_back(mk("rem", 32'hFFFFFFF9, 32'd2, 32'd0, 3'b110, 7'h01, 0, 0, 32'hFFFFFFFF, 0, 33));
        vecs.push_back(mk("divu", 32'd100, 32'd7, 32'd0, 3'b101, 7'h01, 0, 0, 32'd14, 0, 33));
        vecs.push_back(mk("remu", 32'd100, 32'd7, 32'd0, 3'b111, 7'h01, 0, 0, 32'd2, 0, 33));
`else
        vecs.push_back(mk("div_by0", 32'd7, 32'd0, 32'd0, 3'b100, 7'h01, 0, 0, 32'd0, 1, 0));
        vecs.push_back(mk("rem_ovf", 32'h80000000, 32'hFFFFFFFF, 32'd0, 3'b110, 7'h01, 0, 0, 32'd0, 1, 0));
        vecs.push_back(mk("divu", 32'd100, 32'd7, 32'd0, 3'b101, 7'h01, 0, 0, 32'd0, 1, 0));
`endif
        vecs.push_back(mk("add_after", 32'd1, 32'd2, 32'd0, 3'b000, 7'h00, 0, 0, 32'd3, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            v.rd  = 5'(i + 1);
            v.ctl = {1'b1, 3'(i)};
            run(v);
        end

        // MUL aborted by flush in its tenth stalled cycle
        v = mk("mul_flushed", 32'd3, 32'd5, 32'd0, 3'b000, 7'h01, 0, 0, 32'd15, 0, 33);
        v.rd = 5'd9; v.ctl = 4'b1111;
        drive(v);
        n = 0;
        repeat (9) begin
            @(negedge clk);
            if (stall) n++;
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL flush_prestall got=%0d exp=9", n);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        b.name = "flush_bubble"; b.res = '0; b.st = '0; b.rd = '0; b.ctl = '0; b.ill = 1'b0;
        sb.push_back(b);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall got=%b exp=0", stall);
        end
        v = mk("add_post_flush", 32'd20, 32'd22, 32'd0, 3'b000, 7'h00, 0, 0, 32'd42, 0, 0);
        v.rd = 5'd4; v.ctl = 4'b1010;
        run(v);

        @(posedge clk); #1;
        tb_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
